// File: rtl/controle_varredura_servo_if.sv
// Signal bundle between the sweep sequencer, the top-level control FSM,
// and the servo/sensor blocks.
interface controle_varredura_servo_if;
  logic       ligar;
  logic       pronto;
  logic [2:0] posicao;
  logic       medir;
  logic       timeout;
  logic       fim_varredura;
  logic       sentido;
  logic [3:0] db_estado;

  modport master (
    input  ligar,
    input  pronto,
    output posicao,
    output medir,
    output timeout,
    output fim_varredura,
    output sentido,
    output db_estado
  );

  modport slave (
    output ligar,
    output pronto,
    input  posicao,
    input  medir,
    input  timeout,
    input  fim_varredura,
    input  sentido,
    input  db_estado
  );
endinterface

// File: rtl/controle_varredura_servo.sv
// Ping-pong servo sweep over positions 0..7: settle at each position, request
// one distance measurement, then advance once pronto or the timeout arrives.
module controle_varredura_servo #(
  parameter int T_ASSENTAMENTO = 25000000,
  parameter int T_TIMEOUT      = 2500000
) (
  input logic                       clock,
  input logic                       reset,
  controle_varredura_servo_if.master bus
);

  localparam int T_MAX = (T_ASSENTAMENTO > T_TIMEOUT) ? T_ASSENTAMENTO : T_TIMEOUT;
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] ULT_ASSENTA = CW'(T_ASSENTAMENTO - 1);
  localparam logic [CW-1:0] ULT_TIMEOUT = CW'(T_TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ASSENTA = 4'd2,
    MEDE    = 4'd3,
    AGUARDA = 4'd4,
    PROXIMO = 4'd5
  } estado_t;

  estado_t       estado;
  logic [CW-1:0] cnt;
  logic [2:0]    posicao;
  logic          sentido;
  logic          medir;
  logic          timeout;
  logic          fim_varredura;

  logic [2:0]    prox_posicao;
  logic          prox_sentido;
  logic          virada;

  // Next sweep step: reverse at the end points instead of wrapping.
  always_comb begin
    prox_posicao = posicao;
    prox_sentido = sentido;
    virada       = 1'b0;
    if (!sentido) begin
      if (posicao == 3'd7) begin
        prox_posicao = 3'd6;
        prox_sentido = 1'b1;
        virada       = 1'b1;
      end else begin
        prox_posicao = posicao + 3'd1;
      end
    end else begin
      if (posicao == 3'd0) begin
        prox_posicao = 3'd1;
        prox_sentido = 1'b0;
        virada       = 1'b1;
      end else begin
        prox_posicao = posicao - 3'd1;
      end
    end
  end

  // Position moves on the edge entering PROXIMO so fim_varredura lines up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= INICIAL;
      cnt           <= '0;
      posicao       <= 3'd0;
      sentido       <= 1'b0;
      medir         <= 1'b0;
      timeout       <= 1'b0;
      fim_varredura <= 1'b0;
    end else begin
      medir         <= 1'b0;
      timeout       <= 1'b0;
      fim_varredura <= 1'b0;
      if (!bus.ligar && estado != INICIAL) begin
        estado <= INICIAL;
        cnt    <= '0;
      end else begin
        case (estado)
          INICIAL: begin
            if (bus.ligar) estado <= PREPARA;
          end
          PREPARA: begin
            posicao <= 3'd0;
            sentido <= 1'b0;
            cnt     <= '0;
            estado  <= ASSENTA;
          end
          ASSENTA: begin
            if (cnt == ULT_ASSENTA) begin
              cnt    <= '0;
              medir  <= 1'b1;
              estado <= MEDE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          MEDE: begin
            cnt    <= '0;
            estado <= AGUARDA;
          end
          AGUARDA: begin
            if (bus.pronto || cnt == ULT_TIMEOUT) begin
              timeout       <= !bus.pronto;
              posicao       <= prox_posicao;
              sentido       <= prox_sentido;
              fim_varredura <= virada;
              cnt           <= '0;
              estado        <= PROXIMO;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PROXIMO: begin
            cnt    <= '0;
            estado <= ASSENTA;
          end
          default: begin
            cnt    <= '0;
            estado <= INICIAL;
          end
        endcase
      end
    end
  end

  assign bus.posicao       = posicao;
  assign bus.sentido       = sentido;
  assign bus.medir         = medir;
  assign bus.timeout       = timeout;
  assign bus.fim_varredura = fim_varredura;
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed bench for the servo sweep sequencer with T_ASSENTAMENTO=4 and
// T_TIMEOUT=6, so one position takes 12 cycles when pronto never arrives.
module tb_controle_varredura_servo;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  controle_varredura_servo_if ifc ();

  controle_varredura_servo #(
    .T_ASSENTAMENTO(4),
    .T_TIMEOUT     (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs that must all sit at their reset value.
  task automatic check_reset_state(input string tag);
    check_output({tag, "_estado"},  ifc.db_estado, 0);
    check_output({tag, "_posicao"}, ifc.posicao, 0);
    check_output({tag, "_sentido"}, ifc.sentido, 0);
    check_output({tag, "_medir"},   ifc.medir, 0);
    check_output({tag, "_timeout"}, ifc.timeout, 0);
    check_output({tag, "_fim"},     ifc.fim_varredura, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int medir_visto;

    ifc.ligar  = 1'b0;
    ifc.pronto = 1'b0;

    // Reset takes effect before any clock edge.
    #2;
    check_reset_state("reset_async_inicio");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_state("reset_liberado");

    // Start: ligar sampled at edge 0, medir after edge 5.
    ifc.ligar = 1'b1;
    tick();
    check_output("prepara_estado", ifc.db_estado, 1);
    tick();
    check_output("assenta_estado", ifc.db_estado, 2);
    check_output("assenta_posicao", ifc.posicao, 0);
    repeat (3) tick();
    check_output("latencia_medir_cedo", ifc.medir, 0);
    tick();

    // Full sweep with pronto two cycles after each medir.
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("sweep%0d_medir", i), ifc.medir, 1);
      check_output($sformatf("sweep%0d_estado_mede", i), ifc.db_estado, 3);
      check_output($sformatf("sweep%0d_posicao", i), ifc.posicao, seq[i]);
      tick();
      check_output($sformatf("sweep%0d_medir_1ciclo", i), ifc.medir, 0);
      tick();
      ifc.pronto = 1'b1;
      tick();
      ifc.pronto = 1'b0;
      check_output($sformatf("sweep%0d_estado_proximo", i), ifc.db_estado, 5);
      check_output($sformatf("sweep%0d_prox_posicao", i), ifc.posicao, seq[i+1]);
      check_output($sformatf("sweep%0d_sentido", i), ifc.sentido, (i >= 7 && i <= 13) ? 1 : 0);
      check_output($sformatf("sweep%0d_fim", i), ifc.fim_varredura, (i == 7 || i == 14) ? 1 : 0);
      check_output($sformatf("sweep%0d_timeout", i), ifc.timeout, 0);
      tick();
      check_output($sformatf("sweep%0d_fim_1ciclo", i), ifc.fim_varredura, 0);
      repeat (4) tick();
    end

    // No pronto at all: timeout six cycles after entering AGUARDA.
    check_output("to_medir", ifc.medir, 1);
    check_output("to_posicao", ifc.posicao, 2);
    tick();
    repeat (5) tick();
    check_output("to_cedo_timeout", ifc.timeout, 0);
    check_output("to_cedo_estado", ifc.db_estado, 4);
    tick();
    check_output("to_timeout", ifc.timeout, 1);
    check_output("to_estado", ifc.db_estado, 5);
    check_output("to_posicao_avanca", ifc.posicao, 3);
    tick();
    check_output("to_timeout_1ciclo", ifc.timeout, 0);
    repeat (4) tick();
    check_output("to_periodo_medir", ifc.medir, 1);
    check_output("to_periodo_posicao", ifc.posicao, 3);

    // pronto on the last timeout count wins.
    tick();
    repeat (5) tick();
    ifc.pronto = 1'b1;
    tick();
    ifc.pronto = 1'b0;
    check_output("empate_timeout", ifc.timeout, 0);
    check_output("empate_estado", ifc.db_estado, 5);
    check_output("empate_posicao", ifc.posicao, 4);
    repeat (5) tick();
    check_output("mede_pronto_medir", ifc.medir, 1);

    // pronto only during MEDE is ignored.
    ifc.pronto = 1'b1;
    tick();
    ifc.pronto = 1'b0;
    check_output("mede_pronto_estado", ifc.db_estado, 4);
    repeat (5) tick();
    check_output("mede_pronto_cedo", ifc.timeout, 0);
    tick();
    check_output("mede_pronto_timeout", ifc.timeout, 1);
    check_output("mede_pronto_posicao", ifc.posicao, 5);

    // Drop ligar in ASSENTA at position 5.
    tick();
    check_output("parar_assenta", ifc.db_estado, 2);
    ifc.ligar = 1'b0;
    tick();
    check_output("parar_estado", ifc.db_estado, 0);
    check_output("parar_posicao", ifc.posicao, 5);
    medir_visto = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.medir !== 1'b0) medir_visto++;
    end
    check_output("parar_sem_medir", medir_visto, 0);
    check_output("parar_posicao_mantida", ifc.posicao, 5);

    // Restart from PREPARA.
    ifc.ligar = 1'b1;
    tick();
    check_output("reinicio_estado", ifc.db_estado, 1);
    tick();
    check_output("reinicio_posicao", ifc.posicao, 0);
    check_output("reinicio_sentido", ifc.sentido, 0);
    repeat (4) tick();
    check_output("reinicio_medir", ifc.medir, 1);
    tick();
    tick();
    ifc.pronto = 1'b1;
    tick();
    ifc.pronto = 1'b0;
    check_output("reinicio_avanco", ifc.posicao, 1);
    repeat (5) tick();
    check_output("reset_meio_medir", ifc.medir, 1);

    // Async reset between edges while in AGUARDA.
    tick();
    tick();
    check_output("reset_meio_aguarda", ifc.db_estado, 4);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("reset_meio");
    tick();
    ifc.ligar = 1'b0;
    tick();
    reset = 1'b0;
    medir_visto = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ifc.medir !== 1'b0 || ifc.timeout !== 1'b0 || ifc.fim_varredura !== 1'b0) medir_visto++;
    end
    check_output("pos_reset_sem_pulsos", medir_visto, 0);
    check_output("pos_reset_estado", ifc.db_estado, 0);
    ifc.ligar = 1'b1;
    tick();
    check_output("pos_reset_prepara", ifc.db_estado, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
